// File: rtl/memory_game_ctrl.sv
// Two-player 4x4 memory-card game sequencer: card states, cursor, pick/compare
// sequencing, scores and a per-turn countdown feeding the board renderer.
//   state   | meaning
//   IDLE    | no game yet, all cards down
//   PICK1   | waiting for the first card of a turn
//   PICK2   | waiting for the second card of a turn
//   COMPARE | one cycle, symbols of idx1/idx2 compared
//   HOLD    | mismatched pair shown face-up before flipping back
//   DONE    | all pairs matched, winner latched
module memory_game_ctrl #(
  parameter int TICK_CYC     = 100_000_000,
  parameter int HOLD_CYC     = 100_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] deck_syms,
  input  logic        mv_up,
  input  logic        mv_down,
  input  logic        mv_left,
  input  logic        mv_right,
  input  logic        sel,
  output logic [31:0] card_states,
  output logic [3:0]  cursor,
  output logic        player,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic [4:0]  time_left,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {IDLE, PICK1, PICK2, COMPARE, HOLD, DONE} state_e;
  typedef enum logic [1:0] {CS_DOWN = 2'b00, CS_UP = 2'b01, CS_MATCH = 2'b10} card_state_e;

  state_e            state_q, state_d;
  logic [47:0]       deck_q, deck_d;
  logic [15:0][1:0]  cards_q, cards_d;
  logic [3:0]        cursor_q, cursor_d;
  logic              player_q, player_d;
  logic [3:0]        score0_q, score0_d, score1_q, score1_d;
  logic [3:0]        pairs_q, pairs_d;
  logic [4:0]        time_q, time_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [3:0]        idx1_q, idx1_d, idx2_q, idx2_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;

  logic [2:0] sym1, sym2;
  logic [1:0] cur_row, cur_col;

  assign sym1    = deck_q[int'(idx1_q)*3 +: 3];
  assign sym2    = deck_q[int'(idx2_q)*3 +: 3];
  assign cur_row = cursor_q[3:2];
  assign cur_col = cursor_q[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      deck_q      <= '0;
      cards_q     <= '0;
      cursor_q    <= '0;
      player_q    <= 1'b0;
      score0_q    <= '0;
      score1_q    <= '0;
      pairs_q     <= '0;
      time_q      <= 5'(TURN_SECONDS);
      tick_q      <= '0;
      hold_q      <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      deck_q      <= deck_d;
      cards_q     <= cards_d;
      cursor_q    <= cursor_d;
      player_q    <= player_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      pairs_q     <= pairs_d;
      time_q      <= time_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deck_d      = deck_q;
    cards_d     = cards_q;
    cursor_d    = cursor_q;
    player_d    = player_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    pairs_d     = pairs_q;
    time_d      = time_q;
    tick_d      = tick_q;
    hold_d      = hold_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    if (start) begin
      deck_d      = deck_syms;
      cards_d     = '0;
      cursor_d    = '0;
      player_d    = 1'b0;
      score0_d    = '0;
      score1_d    = '0;
      pairs_d     = '0;
      time_d      = 5'(TURN_SECONDS);
      tick_d      = '0;
      hold_d      = '0;
      game_over_d = 1'b0;
      winner_d    = 2'b00;
      state_d     = PICK1;
    end else begin
      case (state_q)
        PICK1, PICK2: begin
          if (time_q == 5'd0) begin
            // Turn expired: any half-made pick is abandoned, inputs this cycle are dropped
            if (state_q == PICK2) cards_d[idx1_q] = CS_DOWN;
            player_d = ~player_q;
            time_d   = 5'(TURN_SECONDS);
            tick_d   = '0;
            state_d  = PICK1;
          end else begin
            if (tick_q == TW'(TICK_CYC - 1)) begin
              tick_d = '0;
              time_d = time_q - 5'd1;
            end else begin
              tick_d = tick_q + TW'(1);
            end
            if (sel && cards_q[cursor_q] == CS_DOWN) begin
              cards_d[cursor_q] = CS_UP;
              if (state_q == PICK1) begin
                idx1_d  = cursor_q;
                state_d = PICK2;
              end else begin
                idx2_d  = cursor_q;
                state_d = COMPARE;
              end
            end
            if (mv_up)         cursor_d = {cur_row - 2'd1, cur_col};
            else if (mv_down)  cursor_d = {cur_row + 2'd1, cur_col};
            else if (mv_left)  cursor_d = {cur_row, cur_col - 2'd1};
            else if (mv_right) cursor_d = {cur_row, cur_col + 2'd1};
          end
        end
        COMPARE: begin
          if (sym1 == sym2) begin
            cards_d[idx1_q] = CS_MATCH;
            cards_d[idx2_q] = CS_MATCH;
            if (player_q) score1_d = score1_q + 4'd1;
            else          score0_d = score0_q + 4'd1;
            pairs_d = pairs_q + 4'd1;
            if (pairs_q == 4'd7) begin
              game_over_d = 1'b1;
              if (score0_d > score1_d)      winner_d = 2'b01;
              else if (score1_d > score0_d) winner_d = 2'b10;
              else                          winner_d = 2'b11;
              state_d = DONE;
            end else begin
              time_d  = 5'(TURN_SECONDS);
              tick_d  = '0;
              state_d = PICK1;
            end
          end else begin
            hold_d  = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (hold_q == HW'(HOLD_CYC - 1)) begin
            cards_d[idx1_q] = CS_DOWN;
            cards_d[idx2_q] = CS_DOWN;
            player_d = ~player_q;
            time_d   = 5'(TURN_SECONDS);
            tick_d   = '0;
            state_d  = PICK1;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign card_states = cards_q;
  assign cursor      = cursor_q;
  assign player      = player_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign time_left   = time_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: directed sequences and a cursor table, with every
// cycle also compared against a rule-level game model.
module tb_memory_game_ctrl;

  localparam int TICK = 10;
  localparam int HOLD = 4;
  localparam int TURN = 3;

  logic        clk = 1'b0;
  logic        rst, start, mv_up, mv_down, mv_left, mv_right, sel;
  logic [47:0] deck_syms;
  logic [31:0] card_states;
  logic [3:0]  cursor, score0, score1;
  logic        player, game_over;
  logic [4:0]  time_left;
  logic [1:0]  winner;

  memory_game_ctrl #(.TICK_CYC(TICK), .HOLD_CYC(HOLD), .TURN_SECONDS(TURN)) dut (
    .clk(clk), .rst(rst), .start(start), .deck_syms(deck_syms),
    .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
    .sel(sel), .card_states(card_states), .cursor(cursor), .player(player),
    .score0(score0), .score1(score1), .time_left(time_left),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_print  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: game rules expressed with arrays, a pick queue and
  // elapsed-cycle arithmetic for the countdown.
  int m_card[16];
  int m_sym[16];
  int m_row, m_col, m_plyr, m_sc0, m_sc1, m_turn, m_hold, m_mode, m_win;
  int m_picks[$];
  // m_mode: 0 no game, 1 picking, 2 comparing, 3 showing mismatch, 4 finished

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin m_card[i] = 0; m_sym[i] = 0; end
    m_row = 0; m_col = 0; m_plyr = 0; m_sc0 = 0; m_sc1 = 0;
    m_turn = 0; m_hold = 0; m_mode = 0; m_win = 0;
    m_picks.delete();
  endfunction

  function automatic void end_turn();
    foreach (m_picks[k]) m_card[m_picks[k]] = 0;
    m_picks.delete();
    m_plyr = 1 - m_plyr;
    m_turn = 0;
    m_mode = 1;
  endfunction

  function automatic void model_step();
    int cur;
    if (rst) begin model_reset(); return; end
    if (start) begin
      model_reset();
      for (int i = 0; i < 16; i++) m_sym[i] = int'(deck_syms[3*i +: 3]);
      m_mode = 1;
      return;
    end
    case (m_mode)
      1: begin
        if (m_turn == TURN * TICK) end_turn();
        else begin
          m_turn++;
          cur = m_row * 4 + m_col;
          if (sel && m_card[cur] == 0) begin
            m_card[cur] = 1;
            m_picks.push_back(cur);
            if (m_picks.size() == 2) m_mode = 2;
          end
          if (mv_up)         m_row = (m_row + 3) % 4;
          else if (mv_down)  m_row = (m_row + 1) % 4;
          else if (mv_left)  m_col = (m_col + 3) % 4;
          else if (mv_right) m_col = (m_col + 1) % 4;
        end
      end
      2: begin
        if (m_sym[m_picks[0]] == m_sym[m_picks[1]]) begin
          m_card[m_picks[0]] = 2;
          m_card[m_picks[1]] = 2;
          if (m_plyr == 0) m_sc0++; else m_sc1++;
          m_picks.delete();
          if (m_sc0 + m_sc1 == 8) begin
            m_mode = 4;
            m_win = (m_sc0 > m_sc1) ? 1 : (m_sc1 > m_sc0) ? 2 : 3;
          end else begin
            m_mode = 1;
            m_turn = 0;
          end
        end else begin
          m_mode = 3;
          m_hold = HOLD;
        end
      end
      3: begin
        m_hold--;
        if (m_hold == 0) end_turn();
      end
      default: ;
    endcase
  endfunction

  function automatic logic [52:0] m_outs();
    logic [31:0] c;
    int t;
    for (int i = 0; i < 16; i++) c[2*i +: 2] = 2'(m_card[i]);
    t = TURN - m_turn / TICK;
    if (t < 0) t = 0;
    return {c, 4'(m_row * 4 + m_col), 1'(m_plyr), 4'(m_sc0), 4'(m_sc1), 5'(t),
            1'(m_mode == 4), 2'(m_win)};
  endfunction

  logic [52:0] dut_outs;
  assign dut_outs = {card_states, cursor, player, score0, score1, time_left, game_over, winner};

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model", 64'(dut_outs), 64'(m_outs()));
    rst = 0; start = 0; sel = 0;
    mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
  endtask

  function automatic logic [47:0] std_deck();
    logic [47:0] d;
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'(i >> 1);
    return d;
  endfunction

  function automatic logic [47:0] rand_deck();
    int s[16];
    int j, tmp;
    logic [47:0] d;
    for (int i = 0; i < 16; i++) s[i] = i >> 1;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
    end
    for (int i = 0; i < 16; i++) d[3*i +: 3] = 3'(s[i]);
    return d;
  endfunction

  task automatic goto(input int target);
    for (int g = 0; g < 8 && (m_row * 4 + m_col) != target; g++) begin
      if (m_row != target / 4) mv_down = 1;
      else                     mv_right = 1;
      step();
    end
  endtask

  task automatic pick(input int idx);
    goto(idx);
    sel = 1;
    step();
  endtask

  task automatic pair(input int a, input int b);
    pick(a);
    pick(b);
    step();
  endtask

  typedef struct packed {
    logic [3:0] mv;       // {up, down, left, right}
    logic [3:0] exp_cur;
  } mv_vec_t;
  mv_vec_t mv_tab[18];

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mv_tab[0]  = {4'b0001, 4'd1};
    mv_tab[1]  = {4'b0001, 4'd2};
    mv_tab[2]  = {4'b0001, 4'd3};
    mv_tab[3]  = {4'b0001, 4'd0};
    mv_tab[4]  = {4'b1000, 4'd12};
    mv_tab[5]  = {4'b1000, 4'd8};
    mv_tab[6]  = {4'b0100, 4'd12};
    mv_tab[7]  = {4'b0100, 4'd0};
    mv_tab[8]  = {4'b0010, 4'd3};
    mv_tab[9]  = {4'b0010, 4'd2};
    mv_tab[10] = {4'b1010, 4'd14};
    mv_tab[11] = {4'b0101, 4'd2};
    mv_tab[12] = {4'b0011, 4'd1};
    mv_tab[13] = {4'b0000, 4'd1};
    mv_tab[14] = {4'b1111, 4'd13};
    mv_tab[15] = {4'b0100, 4'd1};
    mv_tab[16] = {4'b0100, 4'd5};
    mv_tab[17] = {4'b1010, 4'd1};

    rst = 1; start = 0; sel = 0;
    mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
    deck_syms = std_deck();
    model_reset();
    rst = 1; step();
    rst = 1; step();

    // Reset values
    check("rst_cards", 64'(card_states), 64'(0));
    check("rst_cursor", 64'(cursor), 64'(0));
    check("rst_player", 64'(player), 64'(0));
    check("rst_scores", 64'({score0, score1}), 64'(0));
    check("rst_time", 64'(time_left), 64'(3));
    check("rst_over_win", 64'({game_over, winner}), 64'(0));

    // Start, then match cards 0/1
    start = 1; step();
    check("start_time", 64'(time_left), 64'(3));
    sel = 1; step();
    check("pick1_up", 64'(card_states), 64'(32'h1));
    mv_right = 1; step();
    sel = 1; step();
    step();
    check("match_cards", 64'(card_states[3:0]), 64'(4'b1010));
    check("match_score0", 64'(score0), 64'(1));
    check("match_player", 64'(player), 64'(0));
    check("match_time", 64'(time_left), 64'(3));

    // Mismatch 0/2, held face-up then flipped back
    start = 1; step();
    sel = 1; step();
    mv_right = 1; step();
    mv_right = 1; step();
    sel = 1; step();
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= HOLD) check("hold_up", 64'({card_states[5:4], card_states[1:0]}), 64'(4'b0101));
      else begin
        check("hold_down", 64'(card_states), 64'(0));
        check("hold_player", 64'(player), 64'(1));
        check("hold_time", 64'(time_left), 64'(3));
      end
    end

    // Cursor table
    start = 1; step();
    for (int i = 0; i < 18; i++) begin
      {mv_up, mv_down, mv_left, mv_right} = mv_tab[i].mv;
      step();
      check("cursor_tab", 64'(cursor), 64'(mv_tab[i].exp_cur));
    end

    // Timeout with a sel in the timeout cycle
    start = 1; step();
    for (int k = 1; k <= 31; k++) begin
      if (k == 1 || k == 31) sel = 1;
      if (k == 2) mv_right = 1;
      step();
      if (k == 9)  check("tmo_t3", 64'(time_left), 64'(3));
      if (k == 10) check("tmo_t2", 64'(time_left), 64'(2));
      if (k == 20) check("tmo_t1", 64'(time_left), 64'(1));
      if (k == 30) check("tmo_t0", 64'(time_left), 64'(0));
      if (k == 31) begin
        check("tmo_cards", 64'(card_states), 64'(0));
        check("tmo_player", 64'(player), 64'(1));
        check("tmo_reload", 64'(time_left), 64'(3));
      end
    end

    // Full game: P0 takes 5 pairs, hands over on a mismatch, P1 takes 3
    start = 1; step();
    pair(0, 1); pair(2, 3); pair(4, 5); pair(6, 7); pair(8, 9);
    pick(10); pick(12);
    repeat (1 + HOLD) step();
    check("game_handover", 64'(player), 64'(1));
    pair(10, 11); pair(12, 13); pair(14, 15);
    check("game_over", 64'(game_over), 64'(1));
    check("game_winner", 64'(winner), 64'(2'b01));
    check("game_scores", 64'({score0, score1}), 64'({4'd5, 4'd3}));
    check("game_cards", 64'(card_states), 64'(32'hAAAA_AAAA));
    sel = 1; mv_right = 1; step();
    check("done_cursor", 64'(cursor), 64'(15));
    check("done_hold", 64'({game_over, card_states}), 64'({1'b1, 32'hAAAA_AAAA}));
    start = 1; step();
    check("restart_cards", 64'(card_states), 64'(0));
    check("restart_flags", 64'({game_over, winner, score0, score1}), 64'(0));

    // Randomised play against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        start = 1;
        deck_syms = rand_deck();
      end
      if ($urandom_range(0, 1499) == 0) rst = 1;
      if ((c % 500) >= 60) begin
        sel      = ($urandom_range(0, 3) == 0);
        mv_up    = ($urandom_range(0, 5) == 0);
        mv_down  = ($urandom_range(0, 5) == 0);
        mv_left  = ($urandom_range(0, 5) == 0);
        mv_right = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
